tqvp_spi_master: RTL and testbench

TQVP_SPI_MASTER -- requirements
Module: tqvp_spi_master

---
 rtl/tqvp_spi_pkg.sv | 17 +
 rtl/tqvp_spi_master.sv | 136 +++++++++++++
 tb/tb_tqvp_spi_master.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tqvp_spi_pkg.sv
// Register offsets, FSM encoding and register bit positions for the SPI master peripheral.
package tqvp_spi_pkg;

  localparam logic [5:0] ADDR_DATA   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h04;
  localparam logic [5:0] ADDR_CONFIG = 6'h08;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int CFG_CS_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/tqvp_spi_master.sv
// Mode-0 MSB-first SPI master in a 64-byte peripheral slot: one byte per DATA write, 16*(div+1) cycles per transfer.
// Register reads are combinational from address; writes while busy are dropped.
module tqvp_spi_master
  import tqvp_spi_pkg::*;
#(
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  state_e      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [3:0]  ecnt_q, ecnt_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;
  logic        cs_hold_q, cs_hold_d;

  logic wr_en;
  logic busy;
  logic unused_ok;

  assign wr_en     = (data_write_n != 2'b11);
  assign busy      = (state_q == SHIFT);
  assign unused_ok = &{1'b0, data_read_n, data_in[31:9], ui_in[7:3], ui_in[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= 8'h00;
      rx_q      <= 8'h00;
      div_q     <= DIV_RESET;
      hcnt_q    <= 8'h00;
      ecnt_q    <= 4'h0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_hold_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      rx_q      <= rx_d;
      div_q     <= div_d;
      hcnt_q    <= hcnt_d;
      ecnt_q    <= ecnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      cs_hold_q <= cs_hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    rx_d      = rx_q;
    div_d     = div_q;
    hcnt_d    = hcnt_q;
    ecnt_d    = ecnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = done_q;
    cs_hold_d = cs_hold_q;

    if (wr_en && address == ADDR_STATUS && data_in[STAT_DONE]) done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_en && address == ADDR_CONFIG) begin
          div_d     = data_in[7:0];
          cs_hold_d = data_in[CFG_CS_HOLD];
        end
        if (wr_en && address == ADDR_DATA) begin
          state_d = SHIFT;
          shreg_d = data_in[7:0];
          mosi_d  = data_in[7];
          sclk_d  = 1'b0;
          hcnt_d  = 8'h00;
          ecnt_d  = 4'h0;
        end
      end
      SHIFT: begin
        if (hcnt_q == div_q) begin
          hcnt_d = 8'h00;
          ecnt_d = ecnt_q + 4'd1;
          // Rising edge pulls MISO in while the next tx bit moves up to bit 7,
          // ready for the falling edge to present it on mosi.
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[6:0], ui_in[2]};
          end else begin
            sclk_d = 1'b0;
            if (ecnt_q == 4'd15) begin
              state_d = IDLE;
              rx_d    = shreg_q;
              done_d  = 1'b1;
            end else begin
              mosi_d = shreg_q[7];
            end
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_out = 32'h0;
    case (address)
      ADDR_DATA:   data_out = {24'h0, rx_q};
      ADDR_STATUS: data_out = {30'h0, done_q, busy};
      ADDR_CONFIG: data_out = {23'h0, cs_hold_q, div_q};
      default:     data_out = 32'h0;
    endcase
  end

  assign uo_out         = {2'b00, sclk_q, mosi_q, ~(busy | cs_hold_q), 3'b000};
  assign data_ready     = 1'b1;
  assign user_interrupt = done_q;

endmodule

// File: tb/tb_tqvp_spi_master.sv
// Directed bench for tqvp_spi_master: a cycle-level transfer model checked every cycle,
// plus literal expectations for each scenario.
module tb_tqvp_spi_master;
  import tqvp_spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  logic loop_en, miso_val;
  assign ui_in = {5'b0, (loop_en ? uo_out[4] : miso_val), 2'b00};

  tqvp_spi_master #(.DIV_RESET(8'd3)) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer model: a transfer is a count of cycles t since the load; with hp = div+1,
  // half-period h = t/hp, sclk is high on odd h, and mosi shows tx bit 7 - h/2.
  bit       m_busy, m_done, m_hold, m_mosi, m_fin, m_we, m_was_busy;
  int       m_t, hp, h;
  bit [7:0] m_div, m_tx, m_acc, m_rx;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_t = 0; m_div = 8'd3; m_tx = 0; m_acc = 0;
      m_rx = 0; m_done = 0; m_hold = 0; m_mosi = 0;
    end else begin
      hp = int'(m_div) + 1;
      m_fin = 0;
      m_we = (data_write_n != 2'b11);
      m_was_busy = m_busy;
      if (m_busy) begin
        if ((m_t % hp) == hp - 1 && ((m_t / hp) % 2) == 0) m_acc = {m_acc[6:0], ui_in[2]};
        if (m_t == 16 * hp - 1) begin
          m_fin = 1; m_busy = 0; m_rx = m_acc; m_mosi = m_tx[0];
        end else begin
          m_t++;
        end
      end
      if (m_we && address == ADDR_STATUS && data_in[1] && !m_fin) m_done = 0;
      if (m_fin) m_done = 1;
      if (!m_was_busy && m_we && address == ADDR_CONFIG) begin
        m_div = data_in[7:0]; m_hold = data_in[8];
      end
      if (!m_was_busy && m_we && address == ADDR_DATA) begin
        m_busy = 1; m_t = 0; m_tx = data_in[7:0];
      end
    end
  end

  bit          chk_en = 0;
  logic [7:0]  e_uo;
  logic [31:0] e_do;
  bit          e_sclk, e_mosi;
  int          e_h;

  always @(negedge clk) begin
    if (chk_en) begin
      e_h = m_t / (int'(m_div) + 1);
      e_sclk = m_busy ? bit'(e_h % 2) : 1'b0;
      e_mosi = m_busy ? m_tx[7 - e_h / 2] : m_mosi;
      e_uo = {2'b00, e_sclk, e_mosi, ~(m_busy | m_hold), 3'b000};
      case (address)
        ADDR_DATA:   e_do = {24'h0, m_rx};
        ADDR_STATUS: e_do = {30'h0, m_done, m_busy};
        ADDR_CONFIG: e_do = {23'h0, m_hold, m_div};
        default:     e_do = 32'h0;
      endcase
      chk("model_uo_out", {24'h0, uo_out}, {24'h0, e_uo});
      chk("model_data_out", data_out, e_do);
      chk("model_irq", {31'h0, user_interrupt}, {31'h0, m_done});
      chk("model_data_ready", {31'h0, data_ready}, 32'h1);
    end
  end

  // Independent edge monitor: busy cycles, sclk rising edges and mosi seen at each rise.
  int       busy_cnt = 0, rises = 0;
  bit       prev_sclk = 0;
  bit [7:0] cap = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!uo_out[3]) busy_cnt++;
      if (uo_out[5] && !prev_sclk) begin
        rises++;
        cap = {cap[6:0], uo_out[4]};
      end
      prev_sclk = uo_out[5];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
    address = a; data_in = d; data_write_n = w;
    tick();
    data_write_n = 2'b11; data_in = 32'h0;
  endtask

  task automatic rd(input string name, input logic [5:0] a, input logic [31:0] exp);
    address = a; data_read_n = 2'b10;
    #1;
    chk(name, data_out, exp);
    data_read_n = 2'b11;
  endtask

  task automatic wait_idle(input string name, input int max);
    int k;
    k = 0;
    while (uo_out[3] !== 1'b1 && k < max) begin
      tick();
      k++;
    end
    chk(name, {31'h0, k < max}, 32'h1);
  endtask

  int b0, r0;

  initial begin
    rst = 1; address = 0; data_in = 0; data_write_n = 2'b11; data_read_n = 2'b11;
    loop_en = 0; miso_val = 0;
    repeat (3) tick();
    rst = 0;
    chk_en = 1;

    // Reset state
    rd("rst_config", ADDR_CONFIG, 32'h003);
    rd("rst_status", ADDR_STATUS, 32'h0);
    rd("rst_data", ADDR_DATA, 32'h0);
    chk("rst_uo_out", {24'h0, uo_out}, 32'h08);
    chk("rst_irq", {31'h0, user_interrupt}, 32'h0);

    // div=0 loopback 0xA5
    wr(ADDR_CONFIG, 32'h000, 2'b10);
    loop_en = 1;
    b0 = busy_cnt; r0 = rises;
    wr(ADDR_DATA, 32'hA5, 2'b00);
    address = ADDR_STATUS;
    wait_idle("a5_timeout", 100);
    tick();
    chk("a5_busy_cycles", busy_cnt - b0, 16);
    chk("a5_sclk_pulses", rises - r0, 8);
    rd("a5_rx", ADDR_DATA, 32'hA5);
    rd("a5_status", ADDR_STATUS, 32'h2);
    chk("a5_irq", {31'h0, user_interrupt}, 32'h1);

    // div=3, MISO held high, 0x3C
    wr(ADDR_STATUS, 32'h2, 2'b00);
    wr(ADDR_CONFIG, 32'h003, 2'b10);
    loop_en = 0; miso_val = 1;
    b0 = busy_cnt; r0 = rises;
    wr(ADDR_DATA, 32'h3C, 2'b01);
    wait_idle("3c_timeout", 200);
    tick();
    chk("3c_busy_cycles", busy_cnt - b0, 64);
    chk("3c_mosi_seq", {24'h0, cap}, 32'h3C);
    rd("3c_rx", ADDR_DATA, 32'hFF);

    // Writes during busy are dropped
    wr(ADDR_CONFIG, 32'h001, 2'b10);
    loop_en = 1;
    wr(ADDR_DATA, 32'h11, 2'b00);
    repeat (3) tick();
    wr(ADDR_DATA, 32'h22, 2'b00);
    wr(ADDR_CONFIG, 32'h005, 2'b10);
    wait_idle("busy_wr_timeout", 100);
    tick();
    chk("busy_wr_mosi", {24'h0, cap}, 32'h11);
    rd("busy_wr_rx", ADDR_DATA, 32'h11);
    rd("busy_wr_config", ADDR_CONFIG, 32'h001);

    // Clear coincident with completion: set wins; later clear works
    wr(ADDR_STATUS, 32'h2, 2'b00);
    rd("pre_clear_status", ADDR_STATUS, 32'h0);
    wr(ADDR_DATA, 32'h5A, 2'b00);
    repeat (31) tick();
    wr(ADDR_STATUS, 32'h2, 2'b00);
    rd("coinc_status", ADDR_STATUS, 32'h2);
    chk("coinc_irq", {31'h0, user_interrupt}, 32'h1);
    wr(ADDR_STATUS, 32'h2, 2'b10);
    rd("cleared_status", ADDR_STATUS, 32'h0);
    chk("cleared_irq", {31'h0, user_interrupt}, 32'h0);

    // cs_hold keeps cs_n low after completion
    wr(ADDR_CONFIG, 32'h100, 2'b10);
    chk("hold_idle_csn", {31'h0, uo_out[3]}, 32'h0);
    wr(ADDR_DATA, 32'h81, 2'b00);
    repeat (20) tick();
    chk("hold_done_csn", {31'h0, uo_out[3]}, 32'h0);
    rd("hold_status", ADDR_STATUS, 32'h2);
    rd("hold_rx", ADDR_DATA, 32'h81);

    // Reset mid-transfer
    wr(ADDR_STATUS, 32'h2, 2'b00);
    wr(ADDR_CONFIG, 32'h002, 2'b10);
    wr(ADDR_DATA, 32'hFF, 2'b00);
    repeat (10) tick();
    chk("pre_rst_csn", {31'h0, uo_out[3]}, 32'h0);
    rst = 1;
    tick();
    chk("mid_rst_uo_out", {24'h0, uo_out}, 32'h08);
    rd("mid_rst_status", ADDR_STATUS, 32'h0);
    rd("mid_rst_rx", ADDR_DATA, 32'h0);
    rd("mid_rst_config", ADDR_CONFIG, 32'h003);
    chk("mid_rst_irq", {31'h0, user_interrupt}, 32'h0);
    rst = 0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
